// File: rtl/rx_dac_router.sv
// rx_dac_router: multi-channel DAC output stage. Per-channel mode/gain live
// in shadow registers and move to the active set on the first frame after a
// commit. Each lane of each channel runs a 2-stage datapath
// (multiply/select, then shift/saturate/register).

module rx_dac_lane #(
  parameter int SW   = 16,
  parameter int GW   = 8,
  parameter int FRAC = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          s1_en,
  input  logic          s2_en,
  input  logic [1:0]    mode,
  input  logic [GW-1:0] gain,
  input  logic [SW-1:0] sample,
  input  logic [SW-1:0] ramp_val,
  output logic [SW-1:0] data,
  output logic          clip
);
  localparam int PW = SW + GW + 1;
  localparam logic [1:0] M_PASS = 2'd1;
  localparam logic [1:0] M_GAIN = 2'd2;
  localparam logic [1:0] M_RAMP = 2'd3;
  localparam logic signed [PW-1:0] SMAX = {{(PW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  logic signed [PW-1:0] prod_q, prod_d, samp_x, gain_x, shifted;
  logic [SW-1:0]        raw_q, raw_d, data_q, data_d;
  logic                 is_gain_q, is_gain_d;
  logic                 over, under;

  // Stage 1: signed product for gain mode, raw lane value for the other modes.
  always_comb begin
    samp_x    = PW'($signed(sample));
    gain_x    = PW'({1'b0, gain});
    prod_d    = prod_q;
    raw_d     = raw_q;
    is_gain_d = is_gain_q;
    if (s1_en) begin
      prod_d    = samp_x * gain_x;
      is_gain_d = (mode == M_GAIN);
      case (mode)
        M_PASS:  raw_d = sample;
        M_RAMP:  raw_d = ramp_val;
        default: raw_d = '0;
      endcase
    end
  end

  // Stage 2: floor shift, saturate, hold output between valid frames.
  always_comb begin
    shifted = prod_q >>> FRAC;
    over    = shifted > SMAX;
    under   = shifted < SMIN;
    clip    = s2_en && is_gain_q && (over || under);
    data_d  = data_q;
    if (s2_en) begin
      if (!is_gain_q) data_d = raw_q;
      else if (over)  data_d = SMAX[SW-1:0];
      else if (under) data_d = SMIN[SW-1:0];
      else            data_d = shifted[SW-1:0];
    end
  end

  // Lane pipeline registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_q    <= '0;
      raw_q     <= '0;
      is_gain_q <= 1'b0;
      data_q    <= '0;
    end else begin
      prod_q    <= prod_d;
      raw_q     <= raw_d;
      is_gain_q <= is_gain_d;
      data_q    <= data_d;
    end
  end

  assign data = data_q;
endmodule

module rx_dac_router #(
  parameter  int SAMPLES = 8,
  parameter  int SW      = 16,
  parameter  int NCH     = 3,
  parameter  int GW      = 8,
  parameter  int FRAC    = 4,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [SAMPLES*SW-1:0]     adc_data,
  input  logic                      adc_valid,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CW-1:0]             cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [GW-1:0]             cfg_gain,
  input  logic                      cfg_commit,
  output logic [NCH*SAMPLES*SW-1:0] dac_data,
  output logic                      dac_valid,
  output logic [NCH-1:0]            sat_flags
);
  localparam logic [1:0]    M_MUTE  = 2'd0;
  localparam logic [1:0]    M_RAMP  = 2'd3;
  localparam logic [GW-1:0] G_UNITY = GW'(1) << FRAC;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t                      state_q, state_d;
  logic                        apply;
  logic [NCH-1:0][1:0]         sh_mode_q, sh_mode_d, act_mode_q, act_mode_d, eff_mode;
  logic [NCH-1:0][GW-1:0]      sh_gain_q, sh_gain_d, act_gain_q, act_gain_d, eff_gain;
  logic [NCH-1:0][SW-1:0]      base_q, base_d, base_cur;
  logic [NCH-1:0]              sat_q, sat_d, chan_clip;
  logic [1:0]                  vld_pipe_q, vld_pipe_d;
  logic [SAMPLES-1:0][SW-1:0]  adc_lane;
  logic [NCH-1:0][SAMPLES-1:0][SW-1:0] lane_data;
  logic [NCH-1:0][SAMPLES-1:0] lane_clip;

  assign adc_lane = adc_data;

  // Commit FSM next state: arm on commit, fire on the next frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cfg_commit) state_d = S_PENDING;
      S_PENDING: if (adc_valid)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Commit FSM outputs.
  always_comb begin
    cfg_ready = (state_q == S_IDLE);
    apply     = (state_q == S_PENDING) && adc_valid;
  end

  // Shadow writes; only accepted while idle and for existing channels.
  always_comb begin
    sh_mode_d = sh_mode_q;
    sh_gain_d = sh_gain_q;
    if (cfg_valid && cfg_ready && (int'(cfg_ch) < NCH)) begin
      sh_mode_d[cfg_ch] = cfg_mode;
      sh_gain_d[cfg_ch] = cfg_gain;
    end
  end

  // Settings seen by this frame; the applying frame already uses the shadows.
  always_comb begin
    act_mode_d = apply ? sh_mode_q : act_mode_q;
    act_gain_d = apply ? sh_gain_q : act_gain_q;
    for (int c = 0; c < NCH; c++) begin
      eff_mode[c] = apply ? sh_mode_q[c] : act_mode_q[c];
      eff_gain[c] = apply ? sh_gain_q[c] : act_gain_q[c];
      base_cur[c] = (apply && sh_mode_q[c] == M_RAMP && act_mode_q[c] != M_RAMP)
                    ? '0 : base_q[c];
      base_d[c]   = base_q[c];
      if (adc_valid && eff_mode[c] == M_RAMP) base_d[c] = base_cur[c] + SW'(SAMPLES);
    end
  end

  // Sticky saturation: commit clears, a clip in the same cycle wins.
  always_comb begin
    sat_d      = (apply ? '0 : sat_q) | chan_clip;
    vld_pipe_d = {vld_pipe_q[0], adc_valid};
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar l = 0; l < SAMPLES; l++) begin : g_lane
      rx_dac_lane #(.SW(SW), .GW(GW), .FRAC(FRAC)) u_lane (
        .clock    (clock),
        .reset    (reset),
        .s1_en    (adc_valid),
        .s2_en    (vld_pipe_q[0]),
        .mode     (eff_mode[c]),
        .gain     (eff_gain[c]),
        .sample   (adc_lane[l]),
        .ramp_val (base_cur[c] + SW'(l)),
        .data     (lane_data[c][l]),
        .clip     (lane_clip[c][l])
      );
    end
    assign chan_clip[c] = |lane_clip[c];
  end

  // Control and configuration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sh_mode_q  <= {NCH{M_MUTE}};
      sh_gain_q  <= {NCH{G_UNITY}};
      act_mode_q <= {NCH{M_MUTE}};
      act_gain_q <= {NCH{G_UNITY}};
      base_q     <= '0;
      sat_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_mode_q  <= sh_mode_d;
      sh_gain_q  <= sh_gain_d;
      act_mode_q <= act_mode_d;
      act_gain_q <= act_gain_d;
      base_q     <= base_d;
      sat_q      <= sat_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign dac_data  = lane_data;
  assign dac_valid = vld_pipe_q[1];
  assign sat_flags = sat_q;
endmodule

// File: tb/tb_rx_dac_router.sv
// Randomised scoreboard bench for rx_dac_router with a frame-level reference model.
module tb_rx_dac_router;
  localparam int SAMPLES = 8, SW = 16, NCH = 3, GW = 8, FRAC = 4;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW = SAMPLES * SW;
  localparam int DW = NCH * SAMPLES * SW;

  logic clk = 1'b0, reset = 1'b1;
  logic [IW-1:0] adc_data = '0;
  logic adc_valid = 1'b0, cfg_valid = 1'b0, cfg_commit = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [GW-1:0] cfg_gain = '0;
  logic cfg_ready, dac_valid;
  logic [DW-1:0] dac_data;
  logic [NCH-1:0] sat_flags;

  rx_dac_router #(.SAMPLES(SAMPLES), .SW(SW), .NCH(NCH), .GW(GW), .FRAC(FRAC)) dut (
    .clock(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_gain(cfg_gain), .cfg_commit(cfg_commit), .dac_data(dac_data),
    .dac_valid(dac_valid), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state: what software has written and what is in force.
  int  sh_mode[NCH], sh_gain[NCH], act_mode[NCH], act_gain[NCH], base[NCH];
  bit  pending;
  typedef struct { logic [DW-1:0] data; logic [NCH-1:0] clip; int due; } exp_t;
  exp_t exp_q[$];
  int   clr_q[$];
  logic [DW-1:0]  exp_last = '0;
  logic [NCH-1:0] sat_m = '0;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      sh_mode[c] = 0; act_mode[c] = 0; sh_gain[c] = 1 << FRAC; act_gain[c] = 1 << FRAC; base[c] = 0;
    end
    pending = 0;
  endtask

  function automatic logic [IW-1:0] rnd_frame();
    logic [IW-1:0] f;
    for (int i = 0; i < SAMPLES; i++) f[i*SW +: SW] = SW'($urandom);
    return f;
  endfunction

  function automatic logic [SW-1:0] dac_lane(int c, int l);
    return dac_data[(c*SAMPLES+l)*SW +: SW];
  endfunction

  // One clock of stimulus; the model predicts the frame and the config effects.
  task automatic step(bit av, logic [IW-1:0] d, bit cv, int ch, int md, int gn, bit cm);
    exp_t e;
    bit rdy, apply;
    int m, g;
    longint s, p, q, hi, lo, den;
    rdy = !pending;
    chk("cfg_ready", DW'(cfg_ready), DW'(rdy));
    adc_valid = av; adc_data = d; cfg_valid = cv; cfg_ch = CW'(ch);
    cfg_mode = 2'(md); cfg_gain = GW'(gn); cfg_commit = cm;
    apply = pending && av;
    hi = (longint'(1) << (SW-1)) - 1;
    lo = -(longint'(1) << (SW-1));
    den = longint'(1) << FRAC;
    if (av) begin
      e.data = '0; e.clip = '0; e.due = cyc + 2;
      for (int c = 0; c < NCH; c++) begin
        m = apply ? sh_mode[c] : act_mode[c];
        g = apply ? sh_gain[c] : act_gain[c];
        if (apply && m == 3 && act_mode[c] != 3) base[c] = 0;
        for (int i = 0; i < SAMPLES; i++) begin
          s = longint'(d[i*SW +: SW]);
          if (s > hi) s = s - (longint'(1) << SW);
          case (m)
            1: q = s;
            2: begin
              p = s * g;
              q = p / den;
              if (p % den != 0 && p < 0) q = q - 1;
              if (q > hi) begin q = hi; e.clip[c] = 1'b1; end
              if (q < lo) begin q = lo; e.clip[c] = 1'b1; end
            end
            3: q = (base[c] + i) % (1 << SW);
            default: q = 0;
          endcase
          e.data[(c*SAMPLES+i)*SW +: SW] = SW'(q);
        end
        if (m == 3) base[c] = (base[c] + SAMPLES) % (1 << SW);
      end
      exp_q.push_back(e);
    end
    if (apply) begin
      for (int c = 0; c < NCH; c++) begin act_mode[c] = sh_mode[c]; act_gain[c] = sh_gain[c]; end
      pending = 0;
      clr_q.push_back(cyc + 1);
    end
    if (rdy && cv && ch < NCH) begin sh_mode[ch] = md; sh_gain[ch] = gn; end
    if (rdy && cm) pending = 1;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1; adc_valid = 0; cfg_valid = 0; cfg_commit = 0;
    exp_q.delete(); clr_q.delete(); sat_m = '0; exp_last = '0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_dac_valid", DW'(dac_valid), DW'(0));
    chk("rst_dac_data", dac_data, '0);
    chk("rst_sat", DW'(sat_flags), DW'(0));
    chk("rst_cfg_ready", DW'(cfg_ready), DW'(1));
    reset = 1'b0;
  endtask

  // Monitor: consumes expected frames whenever the DUT presents one.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (clr_q.size() > 0 && clr_q[0] <= cyc) begin
          void'(clr_q.pop_front());
          sat_m = '0;
        end
        if (dac_valid) begin
          if (exp_q.size() == 0) chk("unexpected_valid", DW'(dac_valid), DW'(0));
          else begin
            me = exp_q.pop_front();
            chk("latency", DW'(cyc), DW'(me.due));
            chk("dac_data", dac_data, me.data);
            sat_m = sat_m | me.clip;
            exp_last = me.data;
          end
        end else begin
          if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            chk("missing_valid", DW'(dac_valid), DW'(1));
            void'(exp_q.pop_front());
          end
          chk("hold", dac_data, exp_last);
        end
        chk("sat_flags", DW'(sat_flags), DW'(sat_m));
      end
    end
  end

  logic [IW-1:0] fr;
  initial begin
    do_reset(3);
    // Muted after reset.
    for (int i = 0; i < SAMPLES; i++) fr[i*SW +: SW] = SW'(16'h0100 + i);
    step(1, fr, 0, 0, 0, 0, 0); idle(3);
    chk("tp_mute", dac_data, '0);

    // Passthrough / gain 2.0 / gain 0.5.
    step(0, '0, 1, 0, 1, 16, 0);
    step(0, '0, 1, 1, 2, 32, 0);
    step(0, '0, 1, 2, 2, 8, 1);
    idle(2);
    fr = rnd_frame(); fr[0 +: SW] = 16'h1000; fr[SW +: SW] = 16'hFFFD;
    step(1, fr, 0, 0, 0, 0, 0); idle(3);
    chk("tp_ch0_l0", DW'(dac_lane(0, 0)), DW'(16'h1000));
    chk("tp_ch0_l1", DW'(dac_lane(0, 1)), DW'(16'hFFFD));
    chk("tp_ch1_l0", DW'(dac_lane(1, 0)), DW'(16'h2000));
    chk("tp_ch1_l1", DW'(dac_lane(1, 1)), DW'(16'hFFFA));
    chk("tp_ch2_l0", DW'(dac_lane(2, 0)), DW'(16'h0800));
    chk("tp_ch2_l1", DW'(dac_lane(2, 1)), DW'(16'hFFFE));

    // Saturation and commit clear.
    step(0, '0, 1, 1, 2, 255, 1); idle(1);
    fr = rnd_frame(); fr[0 +: SW] = 16'h7000; fr[SW +: SW] = 16'h9000;
    step(1, fr, 0, 0, 0, 0, 0); idle(3);
    chk("tp_sat_hi", DW'(dac_lane(1, 0)), DW'(16'h7FFF));
    chk("tp_sat_lo", DW'(dac_lane(1, 1)), DW'(16'h8000));
    chk("tp_sat_flag", DW'(sat_flags[1]), DW'(1));
    for (int i = 0; i < SAMPLES; i++) fr[i*SW +: SW] = 16'h0010;
    step(0, '0, 0, 0, 0, 0, 1); idle(1);
    step(1, fr, 0, 0, 0, 0, 0); idle(3);
    chk("tp_sat_clear", DW'(sat_flags[1]), DW'(0));

    // Ramp: four frames, then run up to the 0x7FFF -> 0x8000 wrap.
    step(0, '0, 1, 0, 3, 0, 1); idle(1);
    repeat (4) step(1, rnd_frame(), 0, 0, 0, 0, 0);
    idle(3);
    chk("tp_ramp_l0", DW'(dac_lane(0, 0)), DW'(24));
    chk("tp_ramp_l7", DW'(dac_lane(0, 7)), DW'(31));
    repeat (4091) step(1, rnd_frame(), 0, 0, 0, 0, 0);
    step(1, rnd_frame(), 0, 0, 0, 0, 0); idle(3);
    chk("tp_ramp_7fff", DW'(dac_lane(0, 7)), DW'(16'h7FFF));
    step(1, rnd_frame(), 0, 0, 0, 0, 0); idle(3);
    chk("tp_ramp_8000", DW'(dac_lane(0, 0)), DW'(16'h8000));

    // Pending with no frames; writes during pending are dropped.
    step(0, '0, 0, 0, 0, 0, 1);
    repeat (10) step(0, '0, 1, 2, 1, 0, 0);
    chk("tp_pend_ready", DW'(cfg_ready), DW'(0));
    step(1, rnd_frame(), 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 1);
    step(1, rnd_frame(), 0, 0, 0, 0, 0); idle(3);

    // Reset while pending: nothing applied.
    step(0, '0, 1, 0, 1, 0, 1); idle(1);
    do_reset(2);
    fr = rnd_frame(); fr[0 +: SW] = 16'h4321;
    step(1, fr, 0, 0, 0, 0, 0); idle(3);
    chk("tp_rst_pend", DW'(dac_lane(0, 0)), DW'(0));

    // Write + commit + frame in one cycle: new setting only from the next frame.
    step(1, rnd_frame(), 1, 0, 1, 0, 1);
    fr = rnd_frame(); fr[0 +: SW] = 16'h1234;
    step(1, fr, 0, 0, 0, 0, 0); idle(3);
    chk("tp_same_cyc", DW'(dac_lane(0, 0)), DW'(16'h1234));

    // Random traffic.
    for (int k = 0; k < 3000; k++)
      step(($urandom % 4) != 0, rnd_frame(), $urandom % 2, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), ($urandom % 16) == 0);
    idle(5);
    chk("drain", DW'(exp_q.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
